// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: default sizing,
// select-width helper, register names for control decode, read-port indices.
package gpr_pkg;

    localparam int GPR_WIDTH_DEF    = 8;
    localparam int GPR_NUM_REGS_DEF = 4;

    // Register index constants used by the decode/control stage
    localparam int REG_A = 0;
    localparam int REG_B = 1;
    localparam int REG_C = 2;
    localparam int REG_D = 3;

    // Read ports in packed-array order
    typedef enum int {
        PORT_MAIN = 0,
        PORT_LHS  = 1,
        PORT_RHS  = 2
    } port_e;

    localparam int NUM_PORTS = 3;

    // Select width: clog2(n), never less than one bit
    function automatic int gpr_selw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One registered read port of the GPR file: range check, select decode,
// optional write-through forwarding (GPR_BYPASS_EN), output register and
// this port's contribution to the hazard flag.
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int WIDTH    = GPR_WIDTH_DEF,
    parameter int NUM_REGS = GPR_NUM_REGS_DEF,
    parameter int SELW     = gpr_selw(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic [SELW-1:0]                sel,
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  logic [NUM_REGS-1:0]            pending,
    input  logic                           wr_en,
    input  logic [SELW-1:0]                wr_sel,
    input  logic [WIDTH-1:0]               wr_data,
    output logic [WIDTH-1:0]               data,
    output logic                           haz
);

    logic             in_range;
    logic             pend_hit;
    logic             fwd;
    logic [WIDTH-1:0] rd_val;
    logic [WIDTH-1:0] nxt;

    assign in_range = int'(sel) < NUM_REGS;

    // Decode the selected register; out-of-range selects read as zero and never hazard
    always_comb begin
        rd_val   = '0;
        pend_hit = 1'b0;
        if (in_range) begin
            rd_val   = regs[sel];
            pend_hit = pending[sel];
        end
    end

`ifdef GPR_BYPASS_EN
    // Same-cycle write to the register being read is forwarded, so it is not a hazard
    assign fwd = wr_en && (wr_sel == sel) && in_range;
    assign nxt = fwd ? wr_data : rd_val;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_sel, wr_data};
    assign fwd       = 1'b0;
    assign nxt       = rd_val;
`endif

    assign haz = en && pend_hit && !fwd;

    // Output register: load on enable, hold otherwise
    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (en)
            data <= nxt;
    end

endmodule

// File: rtl/gpr_file.sv
// Parametrised general-purpose register file: NUM_REGS x WIDTH registers,
// three registered read ports (main/lhs/rhs), one write port and a pending-write
// scoreboard that reports read-after-write hazards. Define GPR_BYPASS_EN to
// enable same-cycle write-through forwarding on the read ports.
module gpr_file
    import gpr_pkg::*;
#(
    parameter int WIDTH    = GPR_WIDTH_DEF,
    parameter int NUM_REGS = GPR_NUM_REGS_DEF,
    parameter int SELW     = gpr_selw(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [SELW-1:0]     wr_sel,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                main_en,
    input  logic [SELW-1:0]     main_sel,
    output logic [WIDTH-1:0]    main_data,
    output logic                main_oe,
    input  logic                lhs_en,
    input  logic [SELW-1:0]     lhs_sel,
    output logic [WIDTH-1:0]    lhs_data,
    input  logic                rhs_en,
    input  logic [SELW-1:0]     rhs_sel,
    output logic [WIDTH-1:0]    rhs_data,
    input  logic                rsv_en,
    input  logic [SELW-1:0]     rsv_sel,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard
);

    logic [NUM_REGS-1:0][WIDTH-1:0]  regs;
    logic                            wr_ok;
    logic                            rsv_ok;
    logic [NUM_PORTS-1:0]            rd_en;
    logic [NUM_PORTS-1:0][SELW-1:0]  rd_sel;
    logic [NUM_PORTS-1:0][WIDTH-1:0] rd_data;
    logic [NUM_PORTS-1:0]            rd_haz;

    assign wr_ok  = wr_en  && (int'(wr_sel)  < NUM_REGS);
    assign rsv_ok = rsv_en && (int'(rsv_sel) < NUM_REGS);

    // Register array, scoreboard and main-bus enable; reserve is applied last so it wins
    always_ff @(posedge clk) begin
        if (rst) begin
            regs    <= '0;
            pending <= '0;
            main_oe <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[wr_sel]    <= wr_data;
                pending[wr_sel] <= 1'b0;
            end
            if (rsv_ok)
                pending[rsv_sel] <= 1'b1;
            main_oe <= main_en;
        end
    end

    assign rd_en  = {rhs_en, lhs_en, main_en};
    assign rd_sel = {rhs_sel, lhs_sel, main_sel};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        gpr_read_port #(
            .WIDTH    (WIDTH),
            .NUM_REGS (NUM_REGS),
            .SELW     (SELW)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .en      (rd_en[p]),
            .sel     (rd_sel[p]),
            .regs    (regs),
            .pending (pending),
            .wr_en   (wr_en),
            .wr_sel  (wr_sel),
            .wr_data (wr_data),
            .data    (rd_data[p]),
            .haz     (rd_haz[p])
        );
    end

    assign main_data = rd_data[PORT_MAIN];
    assign lhs_data  = rd_data[PORT_LHS];
    assign rhs_data  = rd_data[PORT_RHS];
    assign hazard    = |rd_haz;

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: default 4x8 instance against a behavioural
// model, plus a 6x16 instance for parametrisation and out-of-range selects.
module tb_gpr_file;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-size instance
    logic         rst, wr_en, main_en, lhs_en, rhs_en, rsv_en;
    logic [S-1:0] wr_sel, main_sel, lhs_sel, rhs_sel, rsv_sel;
    logic [W-1:0] wr_data, main_data, lhs_data, rhs_data;
    logic         main_oe, hazard;
    logic [N-1:0] pending;

    // 6 x 16 instance
    logic        b_rst, b_wr_en, b_main_en, b_lhs_en, b_rhs_en, b_rsv_en;
    logic [2:0]  b_wr_sel, b_main_sel, b_lhs_sel, b_rhs_sel, b_rsv_sel;
    logic [15:0] b_wr_data, b_main_data, b_lhs_data, b_rhs_data;
    logic        b_main_oe, b_hazard;
    logic [5:0]  b_pending;

    int n_chk  = 0;
    int n_fail = 0;

    // behavioural model of the default instance
    logic [W-1:0] m_regs [N];
    logic [N-1:0] m_pend;
    logic [W-1:0] m_data [3];
    logic         m_oe;

    gpr_file dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .main_en(main_en), .main_sel(main_sel), .main_data(main_data), .main_oe(main_oe),
        .lhs_en(lhs_en), .lhs_sel(lhs_sel), .lhs_data(lhs_data),
        .rhs_en(rhs_en), .rhs_sel(rhs_sel), .rhs_data(rhs_data),
        .rsv_en(rsv_en), .rsv_sel(rsv_sel), .pending(pending), .hazard(hazard)
    );

    gpr_file #(.WIDTH(16), .NUM_REGS(6)) dut6 (
        .clk(clk), .rst(b_rst),
        .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
        .main_en(b_main_en), .main_sel(b_main_sel), .main_data(b_main_data), .main_oe(b_main_oe),
        .lhs_en(b_lhs_en), .lhs_sel(b_lhs_sel), .lhs_data(b_lhs_data),
        .rhs_en(b_rhs_en), .rhs_sel(b_rhs_sel), .rhs_data(b_rhs_data),
        .rsv_en(b_rsv_en), .rsv_sel(b_rsv_sel), .pending(b_pending), .hazard(b_hazard)
    );

    function automatic logic get_en(input int p);
        return (p == 0) ? main_en : (p == 1) ? lhs_en : rhs_en;
    endfunction

    function automatic logic [S-1:0] get_sel(input int p);
        return (p == 0) ? main_sel : (p == 1) ? lhs_sel : rhs_sel;
    endfunction

    // hazard as described: any enabled read of a pending register, minus forwarded ports
    function automatic logic exp_haz();
        logic h = 1'b0;
        for (int p = 0; p < 3; p++)
            if (get_en(p) && m_pend[get_sel(p)] && !(BYP && wr_en && wr_sel == get_sel(p)))
                h = 1'b1;
        return h;
    endfunction

    // advance one clock and apply the same edge to the model
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < N; r++) m_regs[r] = '0;
            for (int p = 0; p < 3; p++) m_data[p] = '0;
            m_pend = '0;
            m_oe   = 1'b0;
        end else begin
            for (int p = 0; p < 3; p++)
                if (get_en(p))
                    m_data[p] = (BYP && wr_en && wr_sel == get_sel(p)) ? wr_data : m_regs[get_sel(p)];
            m_oe = main_en;
            if (wr_en) begin
                m_regs[wr_sel] = wr_data;
                m_pend[wr_sel] = 1'b0;
            end
            if (rsv_en) m_pend[rsv_sel] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; main_en = 0; lhs_en = 0; rhs_en = 0; rsv_en = 0;
        wr_sel = 0; main_sel = 0; lhs_sel = 0; rhs_sel = 0; rsv_sel = 0; wr_data = 0;
        b_rst = 0; b_wr_en = 0; b_main_en = 0; b_lhs_en = 0; b_rhs_en = 0; b_rsv_en = 0;
        b_wr_sel = 0; b_main_sel = 0; b_lhs_sel = 0; b_rhs_sel = 0; b_rsv_sel = 0; b_wr_data = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; b_rst = 1;
        tick();
        idle();
        wr_en = 1; wr_sel = 2; wr_data = 8'hAA;
        tick();
        idle();
        rst = 1; main_en = 1; lhs_en = 1; rhs_en = 1;
        main_sel = 2; lhs_sel = 2; rhs_sel = 2; rsv_en = 1; rsv_sel = 1;
        tick();
        n_chk++; if (main_data !== 8'h00) begin n_fail++; $display("FAIL reset_main: got %h want 00", main_data); end
        n_chk++; if (lhs_data !== 8'h00) begin n_fail++; $display("FAIL reset_lhs: got %h want 00", lhs_data); end
        n_chk++; if (rhs_data !== 8'h00) begin n_fail++; $display("FAIL reset_rhs: got %h want 00", rhs_data); end
        n_chk++; if (main_oe !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b want 0", main_oe); end
        n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
        // reg 2 must have been cleared by the reset
        rst = 0; rsv_en = 0;
        tick();
        n_chk++; if (lhs_data !== 8'h00) begin n_fail++; $display("FAIL reset_reg2_cleared: got %h want 00", lhs_data); end
        n_chk++; if (main_oe !== 1'b1) begin n_fail++; $display("FAIL oe_after_read: got %b want 1", main_oe); end
        idle();
        tick();
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_sel = 1; wr_data = 8'h5C;
        tick();
        idle();
        lhs_en = 1; lhs_sel = 1;
        tick();
        n_chk++; if (lhs_data !== 8'h5C) begin n_fail++; $display("FAIL write_read_lhs: got %h want 5c", lhs_data); end
        n_chk++; if (rhs_data !== 8'h00) begin n_fail++; $display("FAIL write_read_rhs_hold: got %h want 00", rhs_data); end
        // hold check: lhs keeps its value with en low while reg 1 changes
        idle();
        wr_en = 1; wr_sel = 1; wr_data = 8'h11;
        tick();
        idle();
        tick();
        n_chk++; if (lhs_data !== 8'h5C) begin n_fail++; $display("FAIL lhs_hold: got %h want 5c", lhs_data); end
    endtask

    task automatic test_bypass();
        logic [W-1:0] want;
        idle();
        wr_en = 1; wr_sel = 3; wr_data = 8'h77; rhs_en = 1; rhs_sel = 3;
        tick();
        want = BYP ? 8'h77 : 8'h00;
        n_chk++; if (rhs_data !== want) begin n_fail++; $display("FAIL bypass_rhs: got %h want %h", rhs_data, want); end
        idle();
        rhs_en = 1; rhs_sel = 3;
        tick();
        n_chk++; if (rhs_data !== 8'h77) begin n_fail++; $display("FAIL after_bypass_rhs: got %h want 77", rhs_data); end
        idle();
    endtask

    task automatic test_scoreboard();
        logic want;
        idle();
        rsv_en = 1; rsv_sel = 0;
        tick();
        idle();
        lhs_en = 1; lhs_sel = 0;
        #1;
        n_chk++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_set: got %b want 1", hazard); end
        n_chk++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL sb_pending_set: got %b want 0001", pending); end
        wr_en = 1; wr_sel = 0; wr_data = 8'h3C;
        #1;
        want = !BYP;
        n_chk++; if (hazard !== want) begin n_fail++; $display("FAIL sb_hazard_wr_cycle: got %b want %b", hazard, want); end
        tick();
        wr_en = 0;
        #1;
        n_chk++; if (pending !== 4'b0000) begin n_fail++; $display("FAIL sb_pending_clr: got %b want 0000", pending); end
        n_chk++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clr: got %b want 0", hazard); end
        idle();
        wr_en = 1; wr_sel = 0; wr_data = 8'h42; rsv_en = 1; rsv_sel = 0;
        tick();
        idle();
        n_chk++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL sb_rsv_wins: got %b want 0001", pending); end
        // write to a non-pending register leaves the scoreboard alone
        wr_en = 1; wr_sel = 2; wr_data = 8'h99;
        tick();
        idle();
        n_chk++; if (pending !== 4'b0001) begin n_fail++; $display("FAIL sb_nonpending_write: got %b want 0001", pending); end
        wr_en = 1; wr_sel = 0; wr_data = 8'h42;
        tick();
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_sel   = S'($urandom_range(0, N - 1));
            wr_data  = W'($urandom);
            main_en  = 1'($urandom_range(0, 1));
            lhs_en   = 1'($urandom_range(0, 1));
            rhs_en   = 1'($urandom_range(0, 1));
            main_sel = S'($urandom_range(0, N - 1));
            lhs_sel  = S'($urandom_range(0, N - 1));
            rhs_sel  = S'($urandom_range(0, N - 1));
            rsv_en   = ($urandom_range(0, 2) == 0);
            rsv_sel  = S'($urandom_range(0, N - 1));
            #1;
            n_chk++; if (hazard !== exp_haz()) begin n_fail++; $display("FAIL rnd_hazard[%0d]: got %b want %b", i, hazard, exp_haz()); end
            tick();
            n_chk++; if (main_data !== m_data[0]) begin n_fail++; $display("FAIL rnd_main[%0d]: got %h want %h", i, main_data, m_data[0]); end
            n_chk++; if (lhs_data !== m_data[1]) begin n_fail++; $display("FAIL rnd_lhs[%0d]: got %h want %h", i, lhs_data, m_data[1]); end
            n_chk++; if (rhs_data !== m_data[2]) begin n_fail++; $display("FAIL rnd_rhs[%0d]: got %h want %h", i, rhs_data, m_data[2]); end
            n_chk++; if (main_oe !== m_oe) begin n_fail++; $display("FAIL rnd_oe[%0d]: got %b want %b", i, main_oe, m_oe); end
            n_chk++; if (pending !== m_pend) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %b want %b", i, pending, m_pend); end
        end
        idle();
        tick();
    endtask

    task automatic test_param();
        idle();
        b_wr_en = 1; b_wr_sel = 5; b_wr_data = 16'hBEEF;
        tick();
        idle();
        b_main_en = 1; b_main_sel = 5;
        tick();
        n_chk++; if (b_main_data !== 16'hBEEF) begin n_fail++; $display("FAIL p6_main_reg5: got %h want beef", b_main_data); end
        n_chk++; if (b_main_oe !== 1'b1) begin n_fail++; $display("FAIL p6_main_oe: got %b want 1", b_main_oe); end
        idle();
        b_wr_en = 1; b_wr_sel = 7; b_wr_data = 16'h1234; b_rsv_en = 1; b_rsv_sel = 7;
        tick();
        idle();
        n_chk++; if (b_pending !== 6'b000000) begin n_fail++; $display("FAIL p6_rsv_oor: got %b want 000000", b_pending); end
        b_main_en = 1; b_main_sel = 7; b_lhs_en = 1; b_lhs_sel = 6; b_rhs_en = 1; b_rhs_sel = 5;
        tick();
        n_chk++; if (b_main_data !== 16'h0000) begin n_fail++; $display("FAIL p6_read_sel7: got %h want 0000", b_main_data); end
        n_chk++; if (b_lhs_data !== 16'h0000) begin n_fail++; $display("FAIL p6_read_sel6: got %h want 0000", b_lhs_data); end
        n_chk++; if (b_rhs_data !== 16'hBEEF) begin n_fail++; $display("FAIL p6_reg5_intact: got %h want beef", b_rhs_data); end
        idle();
        b_rsv_en = 1; b_rsv_sel = 4;
        tick();
        idle();
        b_rhs_en = 1; b_rhs_sel = 4;
        #1;
        n_chk++; if (b_hazard !== 1'b1) begin n_fail++; $display("FAIL p6_hazard_reg4: got %b want 1", b_hazard); end
        n_chk++; if (b_pending !== 6'b010000) begin n_fail++; $display("FAIL p6_pending_reg4: got %b want 010000", b_pending); end
        idle();
        tick();
    endtask

    initial begin
        for (int r = 0; r < N; r++) m_regs[r] = '0;
        for (int p = 0; p < 3; p++) m_data[p] = '0;
        m_pend = '0;
        m_oe   = 1'b0;
        idle();
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_random();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_file.md
# gpr_file

Parametrised general-purpose register file for the pipelined CPU. It replaces the fixed four-register group with NUM_REGS registers of WIDTH bits, addressed by encoded selects. It has three registered read ports (Main, LHS, RHS), one write port, and a pending-write scoreboard that flags read-after-write hazards to the pipeline control. It sits between the decode/control stage, which drives the selects, and the ALU operand buses and main bus.

## Interface
Parameters:
- WIDTH, 8, register and bus width in bits
- NUM_REGS, 4, number of registers (2..16; not required to be a power of two)
- SELW, clog2(NUM_REGS) (minimum 1), select width

Ports:
- clk  in  1  single clock, all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_sel  in  SELW  destination register
- wr_data  in  WIDTH  write data, taken from the main bus
- main_en / lhs_en / rhs_en  in  1  read request per port
- main_sel / lhs_sel / rhs_sel  in  SELW  source register per port
- main_data / lhs_data / rhs_data  out  WIDTH  registered read data
- main_oe  out  1  registered main-bus drive enable; the top level builds the tri-state from this
- rsv_en  in  1  reserve (mark pending) a destination at decode
- rsv_sel  in  SELW  register to reserve
- pending  out  NUM_REGS  one bit per register, 1 = write outstanding
- hazard  out  1  combinational: an enabled read selects a pending register

## Operation
- Write: on a clock edge with wr_en=1 and wr_sel<NUM_REGS, regs[wr_sel] <= wr_data and pending[wr_sel] <= 0. If wr_sel>=NUM_REGS, the write is ignored.
- Read port X: on a clock edge with X_en=1, X_data <= regs[X_sel], or 0 if X_sel>=NUM_REGS. With X_en=0, X_data holds its value. main_oe <= main_en every cycle.
- Reserve: on a clock edge with rsv_en=1, pending[rsv_sel] <= 1. If rsv_en and wr_en target the same register in the same cycle, the reserve wins and the pending bit stays 1, so back-to-back producers work. An out-of-range rsv_sel is ignored.
- Hazard: hazard = OR over ports of (X_en & pending[X_sel]). If the bypass is compiled in (see Configuration), a port is excluded from the hazard term when wr_en=1 and wr_sel==X_sel. The block never stalls itself; it only reports the hazard.
- A write to a register that is not pending is legal and raises no flag.
- Any number of ports may read the same register at once.

## Timing
- Reset (rst=1 at an edge): all regs=0, pending=0, main_data=lhs_data=rhs_data=0, main_oe=0. rst overrides every strobe in the same cycle.
- Read latency: 1 cycle from X_en to X_data valid. main_oe is aligned with main_data.
- Write-to-read latency: a value written at edge N is visible through a read sampled at edge N+1, unless the bypass applies (see Configuration).
- Reserve takes effect at the next edge. hazard reflects the pending bits from that edge onward.
- Reset asserted mid-sequence clears outstanding pending bits. Control must re-issue the reservations.

## Configuration
- GPR_BYPASS_EN defined: a read and a write to the same register in the same cycle return wr_data at the next edge (write-through forwarding). That port's hazard term is suppressed for that cycle.
- GPR_BYPASS_EN undefined: a same-cycle read returns the old register value, and hazard stays asserted while pending[X_sel]=1.

## Structure
- Shared package gpr_pkg:
  - default WIDTH and NUM_REGS
  - SELW computation function
  - register index constants REG_A..REG_D (0..3) for control decode
- Sub-module gpr_read_port, instantiated three times. It holds the select decode, the range check, the optional bypass mux, the output register and its per-port hazard term.
- The top level holds the register array, the write logic, the pending vector and the hazard OR.

## Test plan
- Reset: write 0xAA to reg 2, assert rst, then read reg 2 on all ports -> all outputs 0x00, pending=0, main_oe=0.
- Write then read: write 0x5C to reg 1 at edge N; lhs_en with lhs_sel=1 at edge N+1 -> lhs_data=0x5C at N+2; rhs_data unchanged since rhs_en=0.
- Bypass: wr reg 3=0x77 while rhs_sel=3, rhs_en=1 in the same cycle -> rhs_data=0x77 next cycle with GPR_BYPASS_EN, old value (0x00) without it.
- Scoreboard:
  - rsv reg 0, then lhs_en with lhs_sel=0 -> hazard=1, pending=0001.
  - Write reg 0 -> pending=0000 and hazard drops.
  - Simultaneous rsv and wr of reg 0 -> pending stays 0001.
- Parametrisation: NUM_REGS=6, WIDTH=16: write 0xBEEF to reg 5, then read on main -> main_data=0xBEEF, main_oe=1. Write to sel 7 is ignored; a read of sel 7 returns 0x0000.
